// File: rtl/serial_adder_nbit.sv
// ---------------------------------------------------------------------------
// serial_adder_nbit
//
// Purpose:
//   Multi-cycle WIDTH-bit adder: {cout,sum} = a + b + cin.
//   A DIGIT-bit slice adder with a registered carry is iterated N = WIDTH/DIGIT
//   times. Operands enter through a valid/ready handshake, and the result
//   leaves through another one.
//   FSM: IDLE (accept) -> RUN (N slice steps) -> DONE (hold until consumed).
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 1)
//   DIGIT  bits added per clock; must divide WIDTH exactly
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, cin present
//   in_ready   operands can be accepted (high only in IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry in
//   out_valid  sum/cout valid (high only in DONE)
//   out_ready  consumer accepts the result
//   sum        (a+b+cin) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (present only with SERIAL_ADD_OVF_EN)
//
// Build option:
//   SERIAL_ADD_OVF_EN  when defined, adds the ovf output and latches the
//                      operand sign bits needed to compute it.
// ---------------------------------------------------------------------------
module serial_adder_nbit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder_nbit: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic              a_sign_q, a_sign_d;
  logic              b_sign_q, b_sign_d;
  logic              ovf_q, ovf_d;
`endif

  // Slice adder: low DIGIT bits of both shift registers plus the running carry.
  logic [DIGIT:0]    slice_total;
  logic              last_step;
  logic [WIDTH-1:0]  full_res;

  assign slice_total = {1'b0, a_sh_q[DIGIT-1:0]}
                     + {1'b0, b_sh_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};

  assign last_step = (count_q == CW'(N - 1));

  // Result accumulation. Only WIDTH-DIGIT bits need storing: the current slice
  // completes the word, so full_res is the finished sum on the last step.
  generate
    if (N > 1) begin : g_res
      logic [WIDTH-DIGIT-1:0] res_q, res_d;

      assign full_res = {slice_total[DIGIT-1:0], res_q};

      always_comb begin
        res_d = res_q;
        if (state_q == ST_RUN) begin
          // New slice enters from the MSB end; oldest slice moves toward bit 0.
          res_d = full_res[WIDTH-1:DIGIT];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else begin
          res_q <= res_d;
        end
      end
    end else begin : g_nores
      // Single-slice build: the one slice is the whole result.
      assign full_res = slice_total[DIGIT-1:0];
    end
  endgenerate

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          count_d = '0;
`ifdef SERIAL_ADD_OVF_EN
          a_sign_d = a[WIDTH-1];
          b_sign_d = b[WIDTH-1];
`endif
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        carry_d = slice_total[DIGIT];
        count_d = count_q + CW'(1);
        if (last_step) begin
          sum_d   = full_res;
          cout_d  = slice_total[DIGIT];
          count_d = '0;
`ifdef SERIAL_ADD_OVF_EN
          // Like-signed operands producing a differently-signed sum.
          ovf_d   = (a_sign_q == b_sign_q) && (full_res[WIDTH-1] != a_sign_q);
`endif
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
